ctrl_decoder: RTL and testbench
===============================

// Module: ctrl_decoder
// PURPOSE
//   Main control unit of the multi-cycle CPU. Decodes the 6-bit opcode (IR[31:26])
//   into the 14-bit control word consumed by the ID/EX/MEM/WB stages.
//   Decode is purely combinational, with no latency.
//   A registered, sticky illegal-opcode flag gives the CPU a hook for interrupts and traps.
// PARAMETERS
//   W_SIG  14  width of the control word (fixed; do not override)
// PORTS
//   clk        in   1   CPU clock
//   rst        in   1   reset, asynchronous, active-high
//   OP         in   6   opcode field IR[31:26]
//   dec_valid  in   1   high for one cycle when IR holds a fresh instruction
//   signal     out  14  control word (combinational from OP)
//   illegal_op out  1   sticky flag: an unknown opcode was decoded
// BEHAVIOUR
//   Control-word bit map:
//     13 Membyte.
//     12 ALUOP (ALU operation taken from func).
//     11 SA (1 = RA, 0 = PC).
//     10:9 SB (0 = RB, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2).
//     8:7 RegDst (0 = RT, 1 = RD, 2 = $31).
//     6 Mem2Reg, 5 RegW, 4 MemR, 3 MemW.
//     2 PC_S (1 = ALU result, 0 = jump target).
//     1 PCWC (conditional PC write), 0 PCW (unconditional PC write).
//   Decode table (hex OP -> signal):
//     00 R-type                       -> 14'h18A0
//     23 lw                           -> 14'h0C70
//     2B sw                           -> 14'h0C08
//     04 beq, 05 bne                  -> 14'h0602
//     02 j                            -> 14'h0001
//     03 jal                          -> 14'h0321 (A = PC, B = 4; Dst = $31)
//     08,09,0A,0C,0D,0E,0F (I-ALU)    -> 14'h0C20
//     any other OP                    -> 14'h0000 (no register, memory or PC write)
//   signal is fully combinational and X-free for every OP value. It depends only on OP;
//   dec_valid, clk and rst do not affect it.
//   illegal_op is registered:
//     set on posedge clk when dec_valid = 1 and OP is outside the table;
//     holds 1 until rst;
//     dec_valid = 0 leaves the flag unchanged.
//   Reset: illegal_op = 0, asynchronously and immediately. signal stays a function of OP
//   during reset. Reset asserted in the same cycle as an illegal decode: reset wins.
//   Only the opcodes listed above are legal. Bits 13 and 12 never assert together.
// CONFIGURATION
//   CTRL_BYTE_EN defined:
//     OP 20 (lb) -> 14'h2C70, legal.
//     OP 28 (sb) -> 14'h2C08, legal.
//   CTRL_BYTE_EN undefined:
//     OP 20 and OP 28 decode to 14'h0000 and are illegal (set illegal_op).
//     signal[13] is constant 0.
// TESTING
//   - Sweep OP 00..3F with dec_valid = 0 -> signal matches the table; illegal_op stays 0.
//   - OP = 23 -> signal = 0C70.
//     OP = 2B -> signal = 0C08.
//     OP = 04 -> signal = 0602.
//     OP = 03 -> signal = 0321.
//   - OP = 3F with dec_valid = 1 for one cycle -> illegal_op = 1 after the edge;
//     it stays 1 after a later OP = 00 decode.
//   - rst pulse mid-cycle while illegal_op = 1 -> illegal_op = 0 without waiting for clk.
//   - With CTRL_BYTE_EN: OP = 20 -> 2C70, OP = 28 -> 2C08, no flag.
//     Without CTRL_BYTE_EN: OP = 20 -> 0000 and the flag sets.
//   - OP = 0F (lui) -> 0C20; OP = 02 (j) -> 0001 with PC_S = 0.

Source files
------------

// File: rtl/ctrl_decoder_if.sv
// Decode bus between the instruction register and the main control unit.
interface ctrl_decoder_if;
  localparam int unsigned W_SIG = 14;
  localparam int unsigned W_OP  = 6;

  logic [W_OP-1:0]  OP;
  logic             dec_valid;
  logic [W_SIG-1:0] signal;
  logic             illegal_op;

  modport master (output OP, output dec_valid, input signal, input illegal_op);
  modport slave  (input OP, input dec_valid, output signal, output illegal_op);
endinterface

// File: rtl/ctrl_decoder.sv
// Main control unit: combinational opcode -> control word, plus sticky illegal-opcode flag.
// Optional byte load/store opcodes (lb/sb) are enabled by defining CTRL_BYTE_EN.
module ctrl_decoder (
  input  logic            clk,
  input  logic            rst,
  ctrl_decoder_if.slave   bus
);
  localparam int unsigned W_SIG = 14;

  logic [W_SIG-1:0] sig_c;
  logic             legal_c;
  logic             illegal_q;

  // Opcode table; unknown opcodes produce an all-zero (inert) control word
  always_comb begin
    sig_c   = W_SIG'(0);
    legal_c = 1'b1;
    case (bus.OP)
      6'h00: sig_c = 14'h18A0;
      6'h23: sig_c = 14'h0C70;
      6'h2B: sig_c = 14'h0C08;
      6'h04,
      6'h05: sig_c = 14'h0602;
      6'h02: sig_c = 14'h0001;
      6'h03: sig_c = 14'h0321;
      6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E,
      6'h0F: sig_c = 14'h0C20;
`ifdef CTRL_BYTE_EN
      6'h20: sig_c = 14'h2C70;
      6'h28: sig_c = 14'h2C08;
`endif
      default: begin
        sig_c   = W_SIG'(0);
        legal_c = 1'b0;
      end
    endcase
  end

  assign bus.signal = sig_c;

  // Flag stays set until reset so a trap handler can inspect it later
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (bus.dec_valid && !legal_c)
      illegal_q <= 1'b1;
  end

  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_ctrl_decoder.sv
// Scoreboard bench for ctrl_decoder: randomized and directed opcodes vs. a table model.
module tb_ctrl_decoder;
  logic clk;
  logic rst;
  ctrl_decoder_if bus ();

  ctrl_decoder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [5:0]  op;
    logic [13:0] sig;
    logic        flag;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] tbl [64];
  bit          legal_tbl [64];
  bit          mflag;
  logic [5:0]  cur_op;
  bit          cur_v;
  int          total = 0;
  int          bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_sig(input string name, input logic [13:0] got, input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Monitor: compare one queued expectation per cycle, away from the clock edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_sig($sformatf("signal op=%h", e.op), bus.signal, e.sig);
      check_bit($sformatf("illegal_op op=%h", e.op), bus.illegal_op, e.flag);
    end
  end

  // Account for the edge just passed, then apply new inputs and queue the expectation
  task automatic drive(input logic [5:0] op, input bit v);
    @(posedge clk);
    #1;
    if (!rst && cur_v && !legal_tbl[cur_op]) mflag = 1'b1;
    bus.OP = op;
    bus.dec_valid = v;
    cur_op = op;
    cur_v = v;
    sb.push_back('{op: op, sig: tbl[op], flag: mflag});
  endtask

  // Reset pulse in the middle of a cycle; flag must clear without a clock edge
  task automatic mid_reset();
    @(posedge clk);
    bus.dec_valid = 1'b0;
    cur_v = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_bit("async reset clears flag", bus.illegal_op, 1'b0);
    check_sig("signal during reset", bus.signal, tbl[cur_op]);
    rst = 1'b0;
    mflag = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      tbl[i] = 14'h0000;
      legal_tbl[i] = 1'b0;
    end
    tbl[6'h00] = 14'h18A0; tbl[6'h23] = 14'h0C70; tbl[6'h2B] = 14'h0C08;
    tbl[6'h04] = 14'h0602; tbl[6'h05] = 14'h0602; tbl[6'h02] = 14'h0001;
    tbl[6'h03] = 14'h0321;
    foreach (tbl[i]) if (i inside {8, 9, 10, 12, 13, 14, 15}) tbl[i] = 14'h0C20;
`ifdef CTRL_BYTE_EN
    tbl[6'h20] = 14'h2C70; tbl[6'h28] = 14'h2C08;
    legal_tbl[6'h20] = 1'b1; legal_tbl[6'h28] = 1'b1;
`endif
    foreach (tbl[i]) if (tbl[i] != 14'h0000) legal_tbl[i] = 1'b1;

    rst = 1'b1;
    bus.OP = 6'h23;
    bus.dec_valid = 1'b1;
    cur_op = 6'h23;
    cur_v = 1'b0;
    mflag = 1'b0;
    #3;
    check_bit("reset flag", bus.illegal_op, 1'b0);
    check_sig("reset signal", bus.signal, 14'h0C70);
    @(posedge clk);
    #1;
    bus.dec_valid = 1'b0;
    rst = 1'b0;

    // Full opcode sweep without decode strobe
    for (int i = 0; i < 64; i++) drive(6'(i), 1'b0);

    // Directed opcodes
    drive(6'h23, 1'b0); drive(6'h2B, 1'b0); drive(6'h04, 1'b0);
    drive(6'h03, 1'b0); drive(6'h0F, 1'b0); drive(6'h02, 1'b0);
    #2;
    check_bit("j PC_S=0", bus.signal[2], 1'b0);

    // Sticky illegal flag
    drive(6'h3F, 1'b1);
    drive(6'h00, 1'b1);
    drive(6'h00, 1'b0);
    drive(6'h23, 1'b1);
    drive(6'h00, 1'b0);
    #2;
    check_bit("flag sticky", bus.illegal_op, 1'b1);
    mid_reset();

    // Reset asserted across an illegal decode edge: reset wins
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.OP = 6'h3F;
    bus.dec_valid = 1'b1;
    cur_op = 6'h3F;
    @(posedge clk);
    #1;
    check_bit("reset wins over illegal", bus.illegal_op, 1'b0);
    check_sig("signal under reset", bus.signal, 14'h0000);
    bus.dec_valid = 1'b0;
    cur_v = 1'b0;
    rst = 1'b0;
    mflag = 1'b0;

    // Byte opcodes, config-dependent
    drive(6'h20, 1'b1);
    drive(6'h28, 1'b1);
    drive(6'h00, 1'b0);
    mid_reset();

    // Randomized decode traffic with periodic resets
    for (int n = 0; n < 300; n++) begin
      drive(6'($urandom_range(0, 63)), ($urandom_range(0, 4) == 0));
      if (n % 25 == 24) mid_reset();
    end
    drive(6'h00, 1'b0);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
